// File: rtl/nl2_dbank_ahw_mc_if.sv
// Bus bundle between the scrub engine / dbank write pipeline and the address history window.
// The master drives writes and scrub requests, and the slave returns the arbitration result.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 16
`endif

interface nl2_dbank_ahw_mc_if #(
    parameter int N_SRAM          = 4,
    parameter int HIST_DEPTH      = 4,
    parameter int N_WR            = 2,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE
);
    localparam int OCC_W = $clog2(HIST_DEPTH * N_WR + 1);

    logic                              shift_en;
    logic                              flush;
    logic [N_WR-1:0]                   wr_vld;
    logic [N_WR*N_SRAM-1:0]            wr_bnk;
    logic [N_WR*BLOCK_ADDR_SIZE-1:0]   wr_addr;
    logic                              scrub_req;
    logic [N_SRAM-1:0]                 scrub_bnk;
    logic [BLOCK_ADDR_SIZE-1:0]        scrub_addr;
    logic                              scrub_grant;
    logic                              scrub_cancel;
    logic                              scrub_drop;
    logic                              scrub_busy;
    logic [OCC_W-1:0]                  hist_occ;

    modport master (
        output shift_en, flush, wr_vld, wr_bnk, wr_addr,
        output scrub_req, scrub_bnk, scrub_addr,
        input  scrub_grant, scrub_cancel, scrub_drop, scrub_busy, hist_occ
    );

    modport slave (
        input  shift_en, flush, wr_vld, wr_bnk, wr_addr,
        input  scrub_req, scrub_bnk, scrub_addr,
        output scrub_grant, scrub_cancel, scrub_drop, scrub_busy, hist_occ
    );
endinterface

// File: rtl/nl2_dbank_ahw_mc.sv
// Multi-channel address history window. It records recent dbank writes and arbitrates a pending
// scrub with a grant, a cancel with a drain wait, or a drop once the retry budget is spent.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 16
`endif

module nl2_dbank_ahw_mc #(
    parameter int N_SRAM          = 4,
    parameter int HIST_DEPTH      = 4,
    parameter int N_WR            = 2,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int RETRY_MAX       = 3
) (
    input logic               clk,
    input logic               rst_a,
    nl2_dbank_ahw_mc_if.slave bus
);
    localparam int OCC_W    = $clog2(HIST_DEPTH * N_WR + 1);
    localparam int RETRY_W  = $clog2(RETRY_MAX + 1);
    localparam int RETRY_W1 = RETRY_W + 1;
    localparam int DRAIN_W  = $clog2(HIST_DEPTH + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [HIST_DEPTH-1:0][N_WR-1:0]                      vld_q, vld_d;
    logic [HIST_DEPTH-1:0][N_WR-1:0][N_SRAM-1:0]          bnk_q, bnk_d;
    logic [HIST_DEPTH-1:0][N_WR-1:0][BLOCK_ADDR_SIZE-1:0] addr_q, addr_d;

    state_t             state_q, state_d;
    logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic             hit;
    logic [OCC_W-1:0] occ;
    logic             grant, cancel, drop, busy;

    // A flush that coincides with a shift still lets stage 0 capture the live writes.
    always_comb begin
        vld_d  = vld_q;
        bnk_d  = bnk_q;
        addr_d = addr_q;
        if (bus.shift_en) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) begin
                vld_d[i]  = vld_q[i-1] & {N_WR{~bus.flush}};
                bnk_d[i]  = bnk_q[i-1];
                addr_d[i] = addr_q[i-1];
            end
            for (int c = 0; c < N_WR; c++) begin
                vld_d[0][c]  = bus.wr_vld[c];
                bnk_d[0][c]  = bus.wr_bnk[c*N_SRAM +: N_SRAM];
                addr_d[0][c] = bus.wr_addr[c*BLOCK_ADDR_SIZE +: BLOCK_ADDR_SIZE];
            end
        end else if (bus.flush) begin
            vld_d = '0;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            for (int c = 0; c < N_WR; c++) begin
                if (vld_q[i][c] && |(bus.scrub_bnk & bnk_q[i][c]) && addr_q[i][c] == bus.scrub_addr) begin
                    hit = 1'b1;
                end
            end
        end
        for (int c = 0; c < N_WR; c++) begin
            if (bus.wr_vld[c] && |(bus.scrub_bnk & bus.wr_bnk[c*N_SRAM +: N_SRAM]) &&
                bus.wr_addr[c*BLOCK_ADDR_SIZE +: BLOCK_ADDR_SIZE] == bus.scrub_addr) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            for (int c = 0; c < N_WR; c++) begin
                occ = occ + OCC_W'(vld_q[i][c]);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        drain_cnt_d = drain_cnt_q;
        grant       = 1'b0;
        cancel      = 1'b0;
        drop        = 1'b0;
        busy        = 1'b0;
        if (!bus.scrub_req) begin
            state_d     = IDLE;
            retry_cnt_d = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!hit) begin
                        grant       = 1'b1;
                        retry_cnt_d = '0;
                    end else begin
                        cancel = 1'b1;
                        if ({1'b0, retry_cnt_q} + RETRY_W1'(1) < RETRY_W1'(RETRY_MAX)) begin
                            retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                            drain_cnt_d = DRAIN_W'(HIST_DEPTH);
                            state_d     = WAIT;
                        end else begin
                            drop        = 1'b1;
                            retry_cnt_d = '0;
                        end
                    end
                end
                WAIT: begin
                    busy = 1'b1;
                    if (bus.flush || drain_cnt_q == '0) begin
                        drain_cnt_d = '0;
                        state_d     = IDLE;
                    end else if (bus.shift_en) begin
                        drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                        if (drain_cnt_q == DRAIN_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so an asynchronous reset silences them at once.
    assign bus.scrub_grant  = grant  & ~rst_a;
    assign bus.scrub_cancel = cancel & ~rst_a;
    assign bus.scrub_drop   = drop   & ~rst_a;
    assign bus.scrub_busy   = busy   & ~rst_a;
    assign bus.hist_occ     = occ;

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            vld_q       <= '0;
            bnk_q       <= '0;
            addr_q      <= '0;
            state_q     <= IDLE;
            retry_cnt_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            bnk_q       <= bnk_d;
            addr_q      <= addr_d;
            state_q     <= state_d;
            retry_cnt_q <= retry_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end
endmodule
